boot_seq: RTL and testbench
===========================

BOOT_SEQ -- requirements
Module: boot_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, CPU/memory data width.
REQ-002 SHALL have parameter SRAM_ADDR_W, default 15, SRAM byte-address width.
REQ-003 SHALL have parameter BOOTROM_ADDR_W, default 12, boot ROM byte-address width (< SRAM_ADDR_W).
REQ-004 SHALL have parameter RST_CYCLES, default 16, CPU reset hold length (>=2).
REQ-005 SHALL have ports `clk in 1 clock` and `rst in 1 reset`; one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports `cpu_valid in 1 request`, `cpu_wdata in 2 control bits`, `cpu_wstrb in DATA_W/8 write strobe (nonzero=write)`, `cpu_rdata out DATA_W status`, `cpu_ready out 1 ack`.
REQ-007 SHALL have ports `rom_valid out 1 read request`, `rom_addr out BOOTROM_ADDR_W-2 word address`, `rom_rdata in DATA_W read data`, `rom_ready in 1 data valid`.
REQ-008 SHALL have ports `sram_valid out 1 write request`, `sram_addr out SRAM_ADDR_W-2 word address`, `sram_wdata out DATA_W data`, `sram_wstrb out DATA_W/8 strobe`, `sram_ready in 1 write done`.
REQ-009 SHALL have ports `boot out 1 boot-mode flag` and `cpu_rst out 1 CPU reset`.

Function
REQ-010 SHALL implement states COPY_RD, COPY_WR, RUN, RST_HOLD.
REQ-011 SHALL define N_WORDS = 2**(BOOTROM_ADDR_W-2) and word offset OFS = 2**(SRAM_ADDR_W-2) - N_WORDS.
REQ-012 COPY_RD SHALL drive rom_valid=1, rom_addr=idx, holding both until the cycle rom_ready=1; that cycle it SHALL latch rom_rdata and go to COPY_WR.
REQ-013 COPY_WR SHALL drive sram_valid=1, sram_addr=OFS+idx (modulo 2**(SRAM_ADDR_W-2)), sram_wdata=latched word, sram_wstrb=all ones, holding until sram_ready=1.
REQ-014 On sram_ready in COPY_WR: if idx==N_WORDS-1, go to RST_HOLD and clear idx; otherwise increment idx and return to COPY_RD.
REQ-015 SHALL keep at most one outstanding ROM or SRAM request; rom_valid and sram_valid SHALL never be high together.
REQ-016 Outside COPY_RD/COPY_WR, rom_valid and sram_valid SHALL be 0 and sram_wstrb SHALL be 0.
REQ-017 RST_HOLD SHALL hold cpu_rst=1 for RST_CYCLES cycles, then go to RUN.
REQ-018 cpu_rst SHALL be 1 in every state except RUN.
REQ-019 cpu_ready SHALL pulse 1 for exactly one cycle, the cycle after any cpu_valid=1 cycle, in every state.
REQ-020 cpu_rdata SHALL equal {zeros, busy, boot}, with busy=1 in COPY_RD/COPY_WR, registered with cpu_ready.
REQ-021 A CPU write in RUN with cpu_wdata[1]=1 SHALL set boot=1, reset idx=0 and go to COPY_RD (reboot, ROM recopied).
REQ-022 A CPU write in RUN with cpu_wdata[1]=0 SHALL load boot<=cpu_wdata[0] and go to RST_HOLD.
REQ-023 CPU writes in COPY_RD, COPY_WR or RST_HOLD SHALL be acknowledged but not change state or boot.
REQ-024 A CPU write with cpu_wstrb=0 SHALL be a read: no state change.
REQ-025 idx width SHALL be BOOTROM_ADDR_W-2 bits; the RST_HOLD counter SHALL be $clog2(RST_CYCLES)+1 bits.

Reset
REQ-026 rst=1 SHALL force state=COPY_RD, idx=0, boot=1, cpu_rst=1, rom_valid=0, sram_valid=0, cpu_ready=0, cpu_rdata=0, with rom_valid rising the first cycle after rst deasserts.
REQ-027 rst asserted mid-copy SHALL abandon the in-flight request and restart the copy from idx 0.

Structure
REQ-028 State encodings and the OFS/N_WORDS expressions SHALL live in the shared system header alongside SRAM_ADDR_W/BOOTROM_ADDR_W.
REQ-029 SHALL be a single module with no sub-modules; the RST_HOLD counter is inline.

Verification
REQ-030 Using SRAM_ADDR_W=12, BOOTROM_ADDR_W=8 (N_WORDS=64, OFS=960), the bench SHALL cover the following scenarios.
- Reset, ROM word i=0xA500+i, zero-wait memories -> SRAM writes to word addresses 960..1023 with matching data, each word once; cpu_rst falls 16 cycles after the last write; boot=1.
- ROM ready delayed 3 cycles and SRAM ready delayed 2 cycles -> rom_addr and sram_addr stay stable while valid; no overlap; 64 writes.
- In RUN, CPU writes wdata=0b00 -> cpu_ready next cycle; boot=0; cpu_rst=1 for 16 cycles; no memory traffic.
- In RUN, CPU writes wdata=0b10 -> boot=1; full 64-word recopy; cpu_rdata bit1=1 during the copy.
- CPU write wdata=0b00 at idx=10 -> acknowledged, ignored; copy completes; boot stays 1.
- rst pulsed at idx=30 while sram_valid=1 -> sram_valid drops; the next rom_addr is 0.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// Shared system header for the boot sequencer: default address widths,
// FSM encoding, CPU status payload and the ROM-to-SRAM placement helpers.
package boot_seq_pkg;

   localparam int unsigned DATA_W_DEF         = 32;
   localparam int unsigned SRAM_ADDR_W_DEF    = 15;
   localparam int unsigned BOOTROM_ADDR_W_DEF = 12;
   localparam int unsigned RST_CYCLES_DEF     = 16;

   typedef enum logic [1:0] {
      COPY_RD  = 2'd0,
      COPY_WR  = 2'd1,
      RUN      = 2'd2,
      RST_HOLD = 2'd3
   } state_t;

   // Low bits of the CPU-visible status word
   typedef struct packed {
      logic busy;
      logic boot;
   } status_t;

   // Number of 32-bit words in the boot ROM
   function automatic int unsigned n_words(input int unsigned rom_addr_w);
      return 32'd1 << (rom_addr_w - 32'd2);
   endfunction

   // Word offset placing the ROM image at the top of SRAM
   function automatic int unsigned ofs_words(input int unsigned sram_addr_w,
                                             input int unsigned rom_addr_w);
      return (32'd1 << (sram_addr_w - 32'd2)) - n_words(rom_addr_w);
   endfunction

endpackage

// File: rtl/boot_seq.sv
// Boot sequencer: copies the boot ROM into the top of SRAM while holding the
// CPU in reset, then releases it; the CPU can request a reboot or re-reset.
module boot_seq
   import boot_seq_pkg::*;
#(
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned SRAM_ADDR_W    = SRAM_ADDR_W_DEF,
   parameter int unsigned BOOTROM_ADDR_W = BOOTROM_ADDR_W_DEF,
   parameter int unsigned RST_CYCLES     = RST_CYCLES_DEF
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      cpu_valid,
   input  logic [1:0]                cpu_wdata,
   input  logic [DATA_W/8-1:0]       cpu_wstrb,
   output logic [DATA_W-1:0]         cpu_rdata,
   output logic                      cpu_ready,

   output logic                      rom_valid,
   output logic [BOOTROM_ADDR_W-3:0] rom_addr,
   input  logic [DATA_W-1:0]         rom_rdata,
   input  logic                      rom_ready,

   output logic                      sram_valid,
   output logic [SRAM_ADDR_W-3:0]    sram_addr,
   output logic [DATA_W-1:0]         sram_wdata,
   output logic [DATA_W/8-1:0]       sram_wstrb,
   input  logic                      sram_ready,

   output logic                      boot,
   output logic                      cpu_rst
);

   localparam int unsigned ROM_AW  = BOOTROM_ADDR_W - 2;
   localparam int unsigned SRAM_AW = SRAM_ADDR_W - 2;
   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned N_WORDS = n_words(BOOTROM_ADDR_W);
   localparam int unsigned OFS     = ofs_words(SRAM_ADDR_W, BOOTROM_ADDR_W);
   localparam int unsigned CNT_W   = $clog2(RST_CYCLES) + 1;

   localparam logic [ROM_AW-1:0]  IDX_LAST = ROM_AW'(N_WORDS - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [SRAM_AW-1:0] OFS_W    = SRAM_AW'(OFS);

   state_t              state, state_nxt;
   logic [ROM_AW-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic                boot_nxt;
   logic                cpu_wr;
   status_t             status;

   // Next-state, copy index, hold counter and boot flag
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      cnt_nxt     = cnt;
      data_nxt    = sram_wdata;
      boot_nxt    = boot;
      cpu_wr      = cpu_valid && (|cpu_wstrb);
      status.busy = (state == COPY_RD) || (state == COPY_WR);
      status.boot = boot;

      case (state)
         COPY_RD: begin
            if (rom_valid && rom_ready) begin
               data_nxt  = rom_rdata;
               state_nxt = COPY_WR;
            end
         end
         COPY_WR: begin
            if (sram_valid && sram_ready) begin
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  cnt_nxt   = '0;
                  state_nxt = RST_HOLD;
               end else begin
                  idx_nxt   = idx + ROM_AW'(1);
                  state_nxt = COPY_RD;
               end
            end
         end
         RST_HOLD: begin
            if (cnt == CNT_LAST) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            // Bit 1 requests a full reboot; otherwise bit 0 selects boot mode
            if (cpu_wr) begin
               if (cpu_wdata[1]) begin
                  boot_nxt  = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = COPY_RD;
               end else begin
                  boot_nxt  = cpu_wdata[0];
                  cnt_nxt   = '0;
                  state_nxt = RST_HOLD;
               end
            end
         end
         default: begin
            state_nxt = COPY_RD;
            idx_nxt   = '0;
         end
      endcase
   end

   // State register; bus outputs are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= COPY_RD;
         idx        <= '0;
         cnt        <= '0;
         boot       <= 1'b1;
         cpu_rst    <= 1'b1;
         rom_valid  <= 1'b0;
         rom_addr   <= '0;
         sram_valid <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_wstrb <= '0;
         cpu_ready  <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         boot       <= boot_nxt;
         cpu_rst    <= (state_nxt != RUN);
         rom_valid  <= (state_nxt == COPY_RD);
         rom_addr   <= idx_nxt;
         sram_valid <= (state_nxt == COPY_WR);
         sram_addr  <= OFS_W + SRAM_AW'(idx_nxt);
         sram_wdata <= data_nxt;
         sram_wstrb <= {STRB_W{state_nxt == COPY_WR}};
         cpu_ready  <= cpu_valid;
         cpu_rdata  <= cpu_valid ? DATA_W'(status) : '0;
      end
   end

endmodule

// File: tb/tb_boot_seq.sv
// Directed bench for boot_seq: copy-timing vector table plus hand-written
// CPU-control, mid-copy write and mid-copy reset sequences.
module tb_boot_seq;

   localparam int unsigned DW   = 32;
   localparam int unsigned SAW  = 12;
   localparam int unsigned RAW  = 8;
   localparam int unsigned RSTC = 16;
   localparam int unsigned OFSW = 960;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cpu_valid = 1'b0;
   logic [1:0]      cpu_wdata = 2'b00;
   logic [3:0]      cpu_wstrb = 4'h0;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_ready;
   logic            rom_valid;
   logic [RAW-3:0]  rom_addr;
   logic [DW-1:0]   rom_rdata;
   logic            rom_ready;
   logic            sram_valid;
   logic [SAW-3:0]  sram_addr;
   logic [DW-1:0]   sram_wdata;
   logic [3:0]      sram_wstrb;
   logic            sram_ready;
   logic            boot;
   logic            cpu_rst;

   boot_seq #(
      .DATA_W(DW), .SRAM_ADDR_W(SAW), .BOOTROM_ADDR_W(RAW), .RST_CYCLES(RSTC)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_valid(cpu_valid), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .rom_valid(rom_valid), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .rom_ready(rom_ready),
      .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_wstrb(sram_wstrb), .sram_ready(sram_ready),
      .boot(boot), .cpu_rst(cpu_rst)
   );

   always #5 clk = ~clk;

   // Memory models with programmable wait states
   int rom_dly = 0;
   int sram_dly = 0;
   int rom_wait = 0;
   int sram_wait = 0;
   assign rom_ready  = rom_valid && (rom_wait >= rom_dly);
   assign sram_ready = sram_valid && (sram_wait >= sram_dly);
   assign rom_rdata  = 32'hA500 + 32'(rom_addr);

   int cyc = 0;
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      rom_wait  <= (!rom_valid || rom_ready) ? 0 : rom_wait + 1;
      sram_wait <= (!sram_valid || sram_ready) ? 0 : sram_wait + 1;
   end

   // Bus monitor: accumulates protocol and data statistics
   int             wr_total = 0, wr_bad = 0, seq_bad = 0, overlap = 0, unstable = 0;
   int             rom_vcyc = 0, sram_vcyc = 0, last_wr_cyc = 0;
   logic [SAW-3:0] last_addr = '0;
   logic           p_rv = 1'b0, p_rr = 1'b0, p_sv = 1'b0, p_sr = 1'b0;
   logic [RAW-3:0] p_ra = '0;
   logic [SAW-3:0] p_sa = '0;
   logic [DW-1:0]  p_sd = '0;

   always @(negedge clk) begin
      if (rom_valid)  rom_vcyc  <= rom_vcyc + 1;
      if (sram_valid) sram_vcyc <= sram_vcyc + 1;
      if (rom_valid && sram_valid) overlap <= overlap + 1;
      if (!rst && ((p_rv && !p_rr && rom_valid && rom_addr != p_ra) ||
                   (p_sv && !p_sr && sram_valid && (sram_addr != p_sa || sram_wdata != p_sd))))
         unstable <= unstable + 1;
      if (sram_valid && sram_ready) begin
         wr_total    <= wr_total + 1;
         last_wr_cyc <= cyc;
         last_addr   <= sram_addr;
         if (32'(sram_addr) < OFSW || sram_wstrb != 4'hF ||
             sram_wdata != 32'hA500 + 32'(sram_addr) - OFSW)
            wr_bad <= wr_bad + 1;
         if (32'(sram_addr) != OFSW && sram_addr != last_addr + 10'd1)
            seq_bad <= seq_bad + 1;
      end
      p_rv <= rom_valid;  p_rr <= rom_ready;  p_ra <= rom_addr;
      p_sv <= sram_valid; p_sr <= sram_ready; p_sa <= sram_addr; p_sd <= sram_wdata;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_op(input logic [3:0] strb, input logic [1:0] wd);
      cpu_valid = 1'b1;
      cpu_wstrb = strb;
      cpu_wdata = wd;
      tick();
      cpu_valid = 1'b0;
      cpu_wstrb = 4'h0;
      cpu_wdata = 2'b00;
   endtask

   task automatic wait_run(input int budget);
      for (int i = 0; i < budget && cpu_rst; i++) tick();
   endtask

   typedef struct {
      int   rom_dly;
      int   sram_dly;
      int   exp_writes;
      int   exp_hold;
      logic exp_boot;
   } vec_t;

   vec_t vecs[4];
   int   s_wr, s_bad, s_ovl, s_unst, s_rv, s_sv, n;

   initial begin
      vecs[0] = '{rom_dly: 0, sram_dly: 0, exp_writes: 64, exp_hold: 16, exp_boot: 1'b1};
      vecs[1] = '{rom_dly: 3, sram_dly: 2, exp_writes: 64, exp_hold: 16, exp_boot: 1'b1};
      vecs[2] = '{rom_dly: 1, sram_dly: 0, exp_writes: 64, exp_hold: 16, exp_boot: 1'b1};
      vecs[3] = '{rom_dly: 0, sram_dly: 4, exp_writes: 64, exp_hold: 16, exp_boot: 1'b1};

      // Reset state
      tick(); tick();
      check("rst_rom_valid",  32'(rom_valid), 0);
      check("rst_sram_valid", 32'(sram_valid), 0);
      check("rst_cpu_rst",    32'(cpu_rst), 1);
      check("rst_boot",       32'(boot), 1);
      check("rst_cpu_ready",  32'(cpu_ready), 0);
      check("rst_cpu_rdata",  cpu_rdata, 0);

      // Full copies under different memory wait states
      foreach (vecs[v]) begin
         rom_dly  = vecs[v].rom_dly;
         sram_dly = vecs[v].sram_dly;
         rst = 1'b1;
         tick(); tick();
         s_wr = wr_total; s_bad = wr_bad + seq_bad; s_ovl = overlap; s_unst = unstable;
         rst = 1'b0;
         tick();
         check($sformatf("v%0d_first_rom_valid", v), 32'(rom_valid), 1);
         check($sformatf("v%0d_first_rom_addr", v), 32'(rom_addr), 0);
         wait_run(3000);
         check($sformatf("v%0d_reach_run", v), 32'(cpu_rst), 0);
         check($sformatf("v%0d_writes", v), 32'(wr_total - s_wr), 32'(vecs[v].exp_writes));
         check($sformatf("v%0d_data_errs", v), 32'(wr_bad + seq_bad - s_bad), 0);
         check($sformatf("v%0d_last_addr", v), 32'(last_addr), 1023);
         check($sformatf("v%0d_overlap", v), 32'(overlap - s_ovl), 0);
         check($sformatf("v%0d_unstable", v), 32'(unstable - s_unst), 0);
         check($sformatf("v%0d_hold", v), 32'(cyc - last_wr_cyc - 1), 32'(vecs[v].exp_hold));
         check($sformatf("v%0d_boot", v), 32'(boot), 32'(vecs[v].exp_boot));
      end

      // Status read in RUN: single-cycle ack, no state change
      cpu_op(4'h0, 2'b11);
      check("rd_ready", 32'(cpu_ready), 1);
      check("rd_rdata", cpu_rdata, 32'h1);
      tick();
      check("rd_ready_pulse", 32'(cpu_ready), 0);
      check("rd_no_reset", 32'(cpu_rst), 0);

      // Write 00 in RUN: boot cleared, CPU reset for 16 cycles, no traffic
      s_rv = rom_vcyc; s_sv = sram_vcyc;
      cpu_op(4'hF, 2'b00);
      check("w00_ready", 32'(cpu_ready), 1);
      check("w00_boot", 32'(boot), 0);
      n = 0;
      for (int i = 0; i < 100 && cpu_rst; i++) begin
         n++;
         tick();
      end
      check("w00_hold", 32'(n), 16);
      check("w00_rom_traffic", 32'(rom_vcyc - s_rv), 0);
      check("w00_sram_traffic", 32'(sram_vcyc - s_sv), 0);
      check("w00_boot_after", 32'(boot), 0);

      // Write 10 in RUN: reboot with full recopy
      rom_dly = 1; sram_dly = 1;
      s_wr = wr_total; s_bad = wr_bad + seq_bad;
      cpu_op(4'hF, 2'b10);
      check("w10_rdata", cpu_rdata, 32'h0);
      check("w10_boot", 32'(boot), 1);
      check("w10_rom_valid", 32'(rom_valid), 1);
      check("w10_rom_addr", 32'(rom_addr), 0);
      tick(); tick(); tick();
      cpu_op(4'h0, 2'b00);
      check("w10_busy_rdata", cpu_rdata, 32'h3);
      wait_run(3000);
      check("w10_reach_run", 32'(cpu_rst), 0);
      check("w10_writes", 32'(wr_total - s_wr), 64);
      check("w10_data_errs", 32'(wr_bad + seq_bad - s_bad), 0);
      check("w10_hold", 32'(cyc - last_wr_cyc - 1), 16);

      // Write 00 during copy at idx 10: acknowledged, ignored
      rom_dly = 0; sram_dly = 0;
      s_wr = wr_total;
      cpu_op(4'hF, 2'b10);
      for (int i = 0; i < 200 && !(rom_valid && rom_addr == 6'd10); i++) tick();
      check("mid_reach_idx10", 32'(rom_addr), 10);
      cpu_op(4'hF, 2'b00);
      check("mid_ready", 32'(cpu_ready), 1);
      check("mid_rdata", cpu_rdata, 32'h3);
      check("mid_boot", 32'(boot), 1);
      wait_run(3000);
      check("mid_writes", 32'(wr_total - s_wr), 64);
      check("mid_boot_end", 32'(boot), 1);

      // Reset at idx 30 while the SRAM write is pending
      sram_dly = 5;
      cpu_op(4'hF, 2'b10);
      for (int i = 0; i < 1000 && !(sram_valid && 32'(sram_addr) == OFSW + 30); i++) tick();
      check("rst_mid_sram_addr", 32'(sram_addr), OFSW + 30);
      rst = 1'b1;
      tick();
      check("rst_mid_sram_drop", 32'(sram_valid), 0);
      check("rst_mid_rom_idle", 32'(rom_valid), 0);
      s_wr = wr_total; s_bad = wr_bad + seq_bad;
      rst = 1'b0;
      tick();
      check("rst_mid_rom_valid", 32'(rom_valid), 1);
      check("rst_mid_rom_addr", 32'(rom_addr), 0);
      wait_run(5000);
      check("rst_mid_writes", 32'(wr_total - s_wr), 64);
      check("rst_mid_data_errs", 32'(wr_bad + seq_bad - s_bad), 0);
      check("rst_mid_boot", 32'(boot), 1);
      check("total_overlap", 32'(overlap), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
